// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types for the sram-like bus arbiter: owner IDs kept
//               in the outstanding-transaction FIFO, grant FSM states and
//               transfer size encodings.
// Ports       : none (package)
// Config      : SRAM_ARB_ROUND_ROBIN_EN (consumed by sram_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    // Which master issued an accepted request.
    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    // Grant FSM: a grant is held while the slave stalls addr_ok.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } state_e;

    // Transfer size encoding carried on the *_size buses.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : One sram-like channel (request, acceptance and response).
//               The requester uses the master modport; the responder uses
//               the slave modport.
// Ports       : req, wr, size, addr, wdata  (master -> slave)
//               rdata, addr_ok, data_ok     (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface : sram_arbiter_if
`default_nettype wire

// File: rtl/sram_arbiter_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module      : owner_fifo
// Description : DEPTH x 1-bit in-order FIFO of owner IDs for outstanding
//               transactions. Full/empty derive from a registered count, so
//               a pop does not free a slot until the following cycle.
// Ports       : clk, rst (async, active-low)
//               i_push/i_din  - enqueue owner of an accepted request
//               i_pop         - dequeue on a slave response
//               o_dout        - owner at the head
//               o_full/o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   i_push,
    input  owner_e      i_din,
    input  wire logic   i_pop,
    output owner_e      o_dout,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);

    owner_e          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;
    assign o_dout    = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= OWNER_INST;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : owner_fifo
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one sram-like slave channel between the instruction
//               and data masters of the core. A grant is locked until the
//               slave accepts it; accepted owners queue in an in-order FIFO
//               and each slave response goes to the oldest owner.
// Ports       : clk, rst (async, active-low)
//               inst  - instruction master channel (slave modport)
//               data  - data master channel (slave modport)
//               s     - shared slave channel (master modport)
//               err   - sticky: response seen with nothing outstanding
// Config      : SRAM_ARB_ROUND_ROBIN_EN - alternate winner on contention;
//               undefined = data master has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sram_arbiter_if.slave    inst,
    sram_arbiter_if.slave    data,
    sram_arbiter_if.master   s,
    output logic             err
);

    state_e  r_state;
    state_e  w_next;
    logic    w_gnt_inst;
    logic    w_gnt_data;
    logic    w_accept;
    logic    w_pop;
    logic    w_full;
    logic    w_empty;
    owner_e  w_head;
    owner_e  w_push_owner;
    logic    w_prefer_data;
    logic    r_err;

    // ------------------------------------------------------------------
    // Contention policy
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    owner_e r_last_winner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_winner <= OWNER_INST;
        end else if (w_accept) begin
            r_last_winner <= w_push_owner;
        end
    end

    // The master that lost the previous accept wins the next tie.
    assign w_prefer_data = (r_last_winner == OWNER_INST);
`else
    assign w_prefer_data = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_gnt_inst = 1'b0;
        w_gnt_data = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_full) begin
                    if (data.req && (!inst.req || w_prefer_data)) begin
                        w_gnt_data = 1'b1;
                        if (!s.addr_ok) w_next = ST_HOLD_D;
                    end else if (inst.req) begin
                        w_gnt_inst = 1'b1;
                        if (!s.addr_ok) w_next = ST_HOLD_I;
                    end
                end
            end
            ST_HOLD_I: begin
                // A dropped request abandons the grant without a push.
                if (!inst.req) begin
                    w_next = ST_IDLE;
                end else if (!w_full) begin
                    w_gnt_inst = 1'b1;
                    if (s.addr_ok) w_next = ST_IDLE;
                end
            end
            ST_HOLD_D: begin
                if (!data.req) begin
                    w_next = ST_IDLE;
                end else if (!w_full) begin
                    w_gnt_data = 1'b1;
                    if (s.addr_ok) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Keep the slave bus quiet while reset is held, whatever the
        // masters are driving.
        if (!rst) begin
            w_gnt_inst = 1'b0;
            w_gnt_data = 1'b0;
        end
    end

    assign w_accept     = (w_gnt_inst | w_gnt_data) & s.addr_ok;
    assign w_push_owner = w_gnt_data ? OWNER_DATA : OWNER_INST;

    // ------------------------------------------------------------------
    // Request forwarding (combinational)
    // ------------------------------------------------------------------
    always_comb begin
        s.req   = w_gnt_inst | w_gnt_data;
        s.wr    = 1'b0;
        s.size  = 2'd0;
        s.addr  = 32'd0;
        s.wdata = 32'd0;
        if (w_gnt_data) begin
            s.wr    = data.wr;
            s.size  = data.size;
            s.addr  = data.addr;
            s.wdata = data.wdata;
        end else if (w_gnt_inst) begin
            s.wr    = inst.wr;
            s.size  = inst.size;
            s.addr  = inst.addr;
            s.wdata = inst.wdata;
        end
    end

    assign inst.addr_ok = w_gnt_inst & s.addr_ok;
    assign data.addr_ok = w_gnt_data & s.addr_ok;

    // ------------------------------------------------------------------
    // Outstanding owners and response routing
    // ------------------------------------------------------------------
    owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_din   (w_push_owner),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop        = s.data_ok & ~w_empty;
    assign inst.data_ok = w_pop & (w_head == OWNER_INST);
    assign data.data_ok = w_pop & (w_head == OWNER_DATA);
    assign inst.rdata   = s.rdata;
    assign data.rdata   = s.rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (s.data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter. Stimulus pushes the
//               expected accept/response events into queues; a monitor on
//               the falling edge pops and compares whenever the DUT strobes
//               addr_ok or data_ok to a master.
// Config      : SRAM_ARB_ROUND_ROBIN_EN selects the contention table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    typedef struct {
        logic        owner;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    logic err;

    int   n_vec;
    int   n_fail;
    exp_t exp_acc[$];
    exp_t exp_rsp[$];
    exp_t e;

    sram_arbiter_if u_inst_if ();
    sram_arbiter_if u_data_if ();
    sram_arbiter_if u_s_if ();

    sram_arbiter #(
        .DEPTH (4)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .inst (u_inst_if),
        .data (u_data_if),
        .s    (u_s_if),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        u_inst_if.req   = 1'b0; u_inst_if.wr = 1'b0; u_inst_if.size = 2'd2;
        u_inst_if.addr  = 32'd0; u_inst_if.wdata = 32'd0;
        u_data_if.req   = 1'b0; u_data_if.wr = 1'b0; u_data_if.size = 2'd2;
        u_data_if.addr  = 32'd0; u_data_if.wdata = 32'd0;
        u_s_if.rdata    = 32'd0;
        u_s_if.addr_ok  = 1'b0;
        u_s_if.data_ok  = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_acc(input logic own, input logic [31:0] a);
        exp_acc.push_back('{owner: own, val: a});
    endtask

    task automatic push_rsp(input logic own, input logic [31:0] d);
        exp_rsp.push_back('{owner: own, val: d});
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (u_inst_if.addr_ok || u_data_if.addr_ok) begin
            n_vec++;
            if (u_inst_if.addr_ok && u_data_if.addr_ok) begin
                n_fail++;
                $display("FAIL accept: both addr_ok high, only one allowed");
            end else if (exp_acc.size() == 0) begin
                n_fail++;
                $display("FAIL accept: unexpected owner=%0d addr=%h, none expected",
                         u_data_if.addr_ok, u_s_if.addr);
            end else begin
                e = exp_acc.pop_front();
                if (e.owner !== u_data_if.addr_ok || e.val !== u_s_if.addr) begin
                    n_fail++;
                    $display("FAIL accept: got owner=%0d addr=%h, expected owner=%0d addr=%h",
                             u_data_if.addr_ok, u_s_if.addr, e.owner, e.val);
                end
            end
        end
        if (u_inst_if.data_ok || u_data_if.data_ok) begin
            n_vec++;
            if (u_inst_if.data_ok && u_data_if.data_ok) begin
                n_fail++;
                $display("FAIL response: both data_ok high, only one allowed");
            end else if (exp_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL response: unexpected owner=%0d, none expected", u_data_if.data_ok);
            end else begin
                e = exp_rsp.pop_front();
                if (e.owner !== u_data_if.data_ok ||
                    e.val !== (u_data_if.data_ok ? u_data_if.rdata : u_inst_if.rdata)) begin
                    n_fail++;
                    $display("FAIL response: got owner=%0d rdata=%h, expected owner=%0d rdata=%h",
                             u_data_if.data_ok,
                             u_data_if.data_ok ? u_data_if.rdata : u_inst_if.rdata,
                             e.owner, e.val);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic rr_own [4];

    initial begin
        n_vec  = 0;
        n_fail = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        rr_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst = 1'b0;
        idle_in();

        // Reset state with activity on every input
        u_inst_if.req  = 1'b1; u_inst_if.addr = 32'h0000_0040;
        u_s_if.addr_ok = 1'b1; u_s_if.data_ok = 1'b1;
        @(negedge clk);
        chk("rst s_req",        32'(u_s_if.req),        32'd0);
        chk("rst s_addr",       u_s_if.addr,            32'd0);
        chk("rst inst_addr_ok", 32'(u_inst_if.addr_ok), 32'd0);
        chk("rst data_addr_ok", 32'(u_data_if.addr_ok), 32'd0);
        chk("rst inst_data_ok", 32'(u_inst_if.data_ok), 32'd0);
        chk("rst data_data_ok", 32'(u_data_if.data_ok), 32'd0);
        chk("rst err",          32'(err),               32'd0);
        idle_in();
        step();
        rst = 1'b1;
        step();

        // Single inst read: accept at cycle 0, response at cycle 3
        u_inst_if.req = 1'b1; u_inst_if.addr = 32'hBFC0_0000;
        u_s_if.addr_ok = 1'b1;
        push_acc(1'b0, 32'hBFC0_0000);
        @(negedge clk);
        chk("t1 s_wr",   32'(u_s_if.wr),   32'd0);
        chk("t1 s_size", 32'(u_s_if.size), 32'd2);
        step();
        idle_in();
        step();
        step();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'h3C1D_BFC0;
        push_rsp(1'b0, 32'h3C1D_BFC0);
        step();
        idle_in();

        // Simultaneous requests: data first (and it is a byte write), then inst
        u_inst_if.req = 1'b1; u_inst_if.addr = 32'h0000_00A0;
        u_data_if.req = 1'b1; u_data_if.addr = 32'h0000_00D0;
        u_data_if.wr = 1'b1; u_data_if.size = 2'd0; u_data_if.wdata = 32'h0000_00A5;
        u_s_if.addr_ok = 1'b1;
        push_acc(1'b1, 32'h0000_00D0);
        @(negedge clk);
        chk("t2 s_wr",    32'(u_s_if.wr),   32'd1);
        chk("t2 s_size",  32'(u_s_if.size), 32'd0);
        chk("t2 s_wdata", u_s_if.wdata,     32'h0000_00A5);
        step();
        u_data_if.req = 1'b0;
        push_acc(1'b0, 32'h0000_00A0);
        step();
        idle_in();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'h1111_0001;
        push_rsp(1'b1, 32'h1111_0001);
        step();
        u_s_if.rdata = 32'h2222_0002;
        push_rsp(1'b0, 32'h2222_0002);
        step();
        idle_in();

        // Hold: inst stalled three cycles while data requests
        u_inst_if.req = 1'b1; u_inst_if.addr = 32'h0000_0100;
        @(negedge clk);
        chk("t3 hold0 s_addr", u_s_if.addr, 32'h0000_0100);
        step();
        u_data_if.req = 1'b1; u_data_if.addr = 32'h0000_0200;
        @(negedge clk);
        chk("t3 hold1 s_addr", u_s_if.addr, 32'h0000_0100);
        step();
        @(negedge clk);
        chk("t3 hold2 s_addr", u_s_if.addr, 32'h0000_0100);
        step();
        u_s_if.addr_ok = 1'b1;
        push_acc(1'b0, 32'h0000_0100);
        step();
        u_inst_if.req = 1'b0;
        push_acc(1'b1, 32'h0000_0200);
        step();
        idle_in();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'h3333_0003;
        push_rsp(1'b0, 32'h3333_0003);
        step();
        u_s_if.rdata = 32'h4444_0004;
        push_rsp(1'b1, 32'h4444_0004);
        step();
        idle_in();

        // Full: four accepts, fifth blocked until a response frees a slot
        u_inst_if.req = 1'b1; u_s_if.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            u_inst_if.addr = 32'h0000_1000 + 32'(4 * k);
            push_acc(1'b0, u_inst_if.addr);
            step();
        end
        u_inst_if.addr = 32'h0000_1010;
        @(negedge clk);
        chk("t4 full s_req",        32'(u_s_if.req),        32'd0);
        chk("t4 full inst_addr_ok", 32'(u_inst_if.addr_ok), 32'd0);
        step();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'h0000_5000;
        push_rsp(1'b0, 32'h0000_5000);
        @(negedge clk);
        chk("t4 pop-cycle s_req", 32'(u_s_if.req), 32'd0);
        step();
        u_s_if.data_ok = 1'b0;
        push_acc(1'b0, 32'h0000_1010);
        @(negedge clk);
        chk("t4 reassert s_req", 32'(u_s_if.req), 32'd1);
        step();
        idle_in();
        u_s_if.data_ok = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            u_s_if.rdata = 32'h0000_5000 + 32'(k);
            push_rsp(1'b0, u_s_if.rdata);
            step();
        end
        idle_in();

        // Spurious response with an empty FIFO
        @(negedge clk);
        chk("t5 err before", 32'(err), 32'd0);
        step();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'hDEAD_BEEF;
        step();
        idle_in();
        @(negedge clk);
        chk("t5 err set", 32'(err), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5 err reset", 32'(err), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Reset mid-flight with two outstanding
        u_inst_if.req = 1'b1; u_inst_if.addr = 32'h0000_0500; u_s_if.addr_ok = 1'b1;
        push_acc(1'b0, 32'h0000_0500);
        step();
        u_inst_if.req = 1'b0;
        u_data_if.req = 1'b1; u_data_if.addr = 32'h0000_0600;
        push_acc(1'b1, 32'h0000_0600);
        step();
        rst = 1'b0;
        u_inst_if.req = 1'b1;
        exp_rsp.delete();
        @(negedge clk);
        chk("t6 rst s_req",        32'(u_s_if.req),        32'd0);
        chk("t6 rst s_addr",       u_s_if.addr,            32'd0);
        chk("t6 rst inst_addr_ok", 32'(u_inst_if.addr_ok), 32'd0);
        chk("t6 rst data_addr_ok", 32'(u_data_if.addr_ok), 32'd0);
        step();
        idle_in();
        rst = 1'b1;
        step();
        u_s_if.data_ok = 1'b1; u_s_if.rdata = 32'h0000_0777;
        step();
        idle_in();
        @(negedge clk);
        chk("t6 late rsp err", 32'(err), 32'd1);
        step();

        // Contention held four cycles, then responses in accept order
        u_inst_if.req = 1'b1; u_inst_if.addr = 32'h0000_0700;
        u_data_if.req = 1'b1; u_data_if.addr = 32'h0000_0800;
        u_s_if.addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_acc(rr_own[k], rr_own[k] ? 32'h0000_0800 : 32'h0000_0700);
            step();
        end
        idle_in();
        u_s_if.data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            u_s_if.rdata = 32'h0000_00D0 + 32'(k);
            push_rsp(rr_own[k], u_s_if.rdata);
            step();
        end
        idle_in();
        step();

        chk("accept queue drained",   32'(exp_acc.size()), 32'd0);
        chk("response queue drained", 32'(exp_rsp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
